// File: rtl/multicycle_mem_interface_pkg.sv
// rtl/multicycle_mem_interface_pkg.sv - state and access-width encodings for the memory interface
package multicycle_mem_interface_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_DONE = 2'b10
   } mem_state_t;

   localparam logic [1:0] MEM_WIDTH_B      = 2'b00;
   localparam logic [1:0] MEM_WIDTH_H      = 2'b01;
   localparam logic [1:0] MEM_WIDTH_W      = 2'b10;
   localparam int         MEM_UNSIGNED_BIT = 2;
   localparam logic [2:0] FUNCT3_WORD      = 3'b010;

   // funct3 low bits 11 has no narrower meaning, so it falls back to a word access
   function automatic logic [1:0] access_width(input logic [2:0] funct3);
      return (funct3[1:0] == 2'b11) ? MEM_WIDTH_W : funct3[1:0];
   endfunction

endpackage

// File: rtl/multicycle_mem_interface_mem_lane_align.sv
// rtl/multicycle_mem_interface_mem_lane_align.sv - byte-lane steering, load extension and misalignment check
module mem_lane_align
   import multicycle_mem_interface_pkg::*;
(
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   input  logic [31:0] store_data,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [1:0]  width;
   logic        is_unsigned;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      width       = access_width(funct3);
      is_unsigned = funct3[MEM_UNSIGNED_BIT];
      case (addr)
         2'd0:    byte_sel = bus_rdata[7:0];
         2'd1:    byte_sel = bus_rdata[15:8];
         2'd2:    byte_sel = bus_rdata[23:16];
         default: byte_sel = bus_rdata[31:24];
      endcase
      half_sel = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

      be         = 4'b1111;
      wdata      = store_data;
      load_data  = bus_rdata;
      misaligned = 1'b0;
      case (width)
         MEM_WIDTH_B: begin
            be         = 4'b0001 << addr;
            wdata      = {4{store_data[7:0]}};
            load_data  = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         MEM_WIDTH_H: begin
            be         = addr[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{store_data[15:0]}};
            load_data  = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            misaligned = addr[0];
         end
         default: begin
            misaligned = |addr;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_mem_interface.sv
// rtl/multicycle_mem_interface.sv - controller-to-bus bridge: req/ack handshake, stall, alignment and fault detection
module multicycle_mem_interface
   import multicycle_mem_interface_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read_enable,
   input  logic        mem_write_enable,
   input  logic        inst_or_data,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic [31:0] store_data,
   input  logic [2:0]  inst_funct3,
   output logic        stall,
   output logic [31:0] read_data,
   output logic        mem_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   mem_state_t    state, state_next;
   logic [CW-1:0] tmo_cnt, tmo_cnt_inc;
   logic [1:0]    lane_q;
   logic [2:0]    funct3_q;
   logic [31:0]   req_addr;
   logic [2:0]    req_funct3;
   logic [1:0]    sel_lane;
   logic [2:0]    sel_funct3;
   logic          access;
   logic          timed_out;
   logic [3:0]    al_be;
   logic [31:0]   al_wdata;
   logic [31:0]   al_load;
   logic          al_mis;

   // In IDLE the aligner sees the live request; afterwards it sees the latched lane/width for load extraction
   always_comb begin
      req_addr    = inst_or_data ? alu_out : pc;
      req_funct3  = inst_or_data ? inst_funct3 : FUNCT3_WORD;
      sel_lane    = (state == ST_IDLE) ? req_addr[1:0] : lane_q;
      sel_funct3  = (state == ST_IDLE) ? req_funct3 : funct3_q;
      access      = mem_read_enable | mem_write_enable;
      tmo_cnt_inc = tmo_cnt + 1'b1;
      timed_out   = (TIMEOUT_CYCLES != 0) && (tmo_cnt_inc == CW'(TIMEOUT_CYCLES));
   end

   mem_lane_align u_align (
      .addr       (sel_lane),
      .funct3     (sel_funct3),
      .store_data (store_data),
      .bus_rdata  (bus_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_data  (al_load),
      .misaligned (al_mis)
   );

   always_comb begin
      state_next = state;
      stall      = 1'b0;
      case (state)
         ST_IDLE: begin
            stall = access;
            if (access) state_next = al_mis ? ST_DONE : ST_BUS;
         end
         ST_BUS: begin
            stall = 1'b1;
            if (bus_ack || timed_out) state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
         read_data <= '0;
         mem_fault <= 1'b0;
         tmo_cnt   <= '0;
         lane_q    <= '0;
         funct3_q  <= '0;
      end else begin
         state     <= state_next;
         mem_fault <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (access) begin
                  lane_q    <= req_addr[1:0];
                  funct3_q  <= req_funct3;
                  bus_addr  <= {req_addr[31:2], 2'b00};
                  bus_be    <= mem_write_enable ? al_be : 4'hF;
                  bus_wdata <= mem_write_enable ? al_wdata : '0;
                  tmo_cnt   <= '0;
                  if (al_mis) begin
                     mem_fault <= 1'b1;
                     read_data <= '0;
                  end else begin
                     bus_req <= 1'b1;
                     bus_we  <= mem_write_enable;
                  end
               end
            end
            ST_BUS: begin
               tmo_cnt <= tmo_cnt_inc;
               // ack wins over a timeout landing in the same cycle
               if (bus_ack) begin
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  read_data <= al_load;
               end else if (timed_out) begin
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  mem_fault <= 1'b1;
                  read_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (!reset && state == ST_IDLE)
         assert (!(mem_read_enable && mem_write_enable))
            else $warning("read and write strobes both high; write takes priority");
   end
`endif

endmodule
